match_scorekeeper: RTL and testbench

- Rule engine that sits directly downstream of the game-control stage and directly upstream of the score display.
- Consumes one-cycle "point won" pulses and keeps both players' scores.
- Applies win-at-WIN_SCORE with win-by-two (deuce/advantage), rotates serve, and flags game over.
- Drives the 4-bit score buses the display stage reads, plus a play_active level that gates the ball logic.

---
 rtl/pingpong_pkg.sv | 27 ++
 rtl/serve_rotator.sv | 45 ++++
 rtl/match_scorekeeper.sv | 149 ++++++++++++++
 tb/tb_match_scorekeeper.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared encodings for the ping-pong game pipeline: FSM states, player ids
// and advantage codes used by game control, scorekeeping and display.
package pingpong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_DEUCE  = 3'd2,
        ST_ADV_P1 = 3'd3,
        ST_ADV_P2 = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    typedef enum logic [1:0] {
        ADV_NONE = 2'b00,
        ADV_P1   = 2'b01,
        ADV_P2   = 2'b10
    } adv_t;

    function automatic adv_t adv_code(input logic player);
        return (player == P2) ? ADV_P2 : ADV_P1;
    endfunction

endpackage

// File: rtl/serve_rotator.sv
// Tracks who serves: rotates every SERVE_SWAP accepted points in normal play,
// every point once deuce is reached, and hands the first serve to the loser.
module serve_rotator
    import pingpong_pkg::*;
#(
    parameter int SERVE_SWAP = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic point_accepted,
    input  logic deuce_mode,
    input  logic new_game,
    input  logic loser,
    output logic server
);

    localparam logic [2:0] SWAP = 3'(SERVE_SWAP);

    logic [2:0] serve_cnt;
    logic [2:0] cnt_inc;

    assign cnt_inc = serve_cnt + 3'd1;

    // point_accepted excludes the game-winning point, so the final server stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            server    <= P1;
            serve_cnt <= 3'd0;
        end else if (new_game) begin
            server    <= loser;
            serve_cnt <= 3'd0;
        end else if (point_accepted) begin
            if (deuce_mode) begin
                server    <= ~server;
                serve_cnt <= 3'd0;
            end else if (cnt_inc == SWAP) begin
                server    <= ~server;
                serve_cnt <= 3'd0;
            end else begin
                serve_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/match_scorekeeper.sv
// Match rule engine: turns point pulses into scores, deuce/advantage tracking,
// game-over/winner flags and the play_active gate for the ball logic.
module match_scorekeeper
    import pingpong_pkg::*;
#(
    parameter int WIN_SCORE  = 7,
    parameter int SERVE_SWAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       start,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       server,
    output logic [1:0] adv,
    output logic       play_active,
    output logic       game_over,
    output logic       winner
);

    localparam logic [3:0] WIN  = 4'(WIN_SCORE);
    localparam logic [3:0] LAST = 4'(WIN_SCORE - 1);
    localparam logic [3:0] PRE  = 4'(WIN_SCORE - 2);

    state_t     state;
    logic       valid;
    logic       scorer;
    logic [3:0] score_mine;
    logic [3:0] score_theirs;
    logic       win_pt;
    logic       to_deuce;
    logic       in_rally;
    logic       point_accepted;
    logic       deuce_mode;
    logic       new_game;

    always_comb begin
        valid        = point_p1 ^ point_p2;
        scorer       = point_p2 ? P2 : P1;
        score_mine   = (scorer == P2) ? score_p2 : score_p1;
        score_theirs = (scorer == P2) ? score_p1 : score_p2;
        in_rally     = (state == ST_PLAY) || (state == ST_DEUCE) ||
                       (state == ST_ADV_P1) || (state == ST_ADV_P2);
        win_pt       = 1'b0;
        to_deuce     = 1'b0;
        if (valid) begin
            case (state)
                ST_PLAY: begin
                    win_pt   = (score_mine == LAST) && (score_theirs < LAST);
                    to_deuce = (score_mine == PRE) && (score_theirs == LAST);
                end
                ST_ADV_P1: win_pt = (scorer == P1);
                ST_ADV_P2: win_pt = (scorer == P2);
                default:   ;
            endcase
        end
        point_accepted = in_rally && valid && !win_pt;
        deuce_mode     = to_deuce || (state == ST_DEUCE) ||
                         (state == ST_ADV_P1) || (state == ST_ADV_P2);
        new_game       = (state == ST_OVER) && start;
    end

    serve_rotator #(
        .SERVE_SWAP(SERVE_SWAP)
    ) u_serve_rotator (
        .clk            (clk),
        .rst            (rst),
        .point_accepted (point_accepted),
        .deuce_mode     (deuce_mode),
        .new_game       (new_game),
        .loser          (~winner),
        .server         (server)
    );

    // Conflicting pulses (both high) leave valid low, so every branch ignores them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            score_p1    <= 4'd0;
            score_p2    <= 4'd0;
            adv         <= ADV_NONE;
            play_active <= 1'b0;
            game_over   <= 1'b0;
            winner      <= P1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_PLAY;
                        play_active <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (valid) begin
                        if (win_pt) begin
                            state       <= ST_OVER;
                            winner      <= scorer;
                            play_active <= 1'b0;
                            game_over   <= 1'b1;
                        end else if (to_deuce) begin
                            state <= ST_DEUCE;
                        end
                        if (scorer == P1) score_p1 <= score_p1 + 4'd1;
                        else              score_p2 <= score_p2 + 4'd1;
                    end
                end
                ST_DEUCE: begin
                    if (valid) begin
                        state <= (scorer == P2) ? ST_ADV_P2 : ST_ADV_P1;
                        adv   <= adv_code(scorer);
                    end
                end
                ST_ADV_P1, ST_ADV_P2: begin
                    if (valid) begin
                        adv <= ADV_NONE;
                        if (win_pt) begin
                            state       <= ST_OVER;
                            winner      <= scorer;
                            play_active <= 1'b0;
                            game_over   <= 1'b1;
                            if (scorer == P1) score_p1 <= WIN;
                            else              score_p2 <= WIN;
                        end else begin
                            state <= ST_DEUCE;
                        end
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state       <= ST_PLAY;
                        score_p1    <= 4'd0;
                        score_p2    <= 4'd0;
                        adv         <= ADV_NONE;
                        play_active <= 1'b1;
                        game_over   <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    play_active <= 1'b0;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_scorekeeper.sv
// Scoreboard bench for match_scorekeeper: directed game scenarios plus random
// rallies, checked against a point-by-point model of the match rules.
module tb_match_scorekeeper;

    localparam int W  = 7;
    localparam int SW = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic       start = 1'b0;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       server;
    logic [1:0] adv;
    logic       play_active;
    logic       game_over;
    logic       winner;

    always #5 clk = ~clk;

    match_scorekeeper #(
        .WIN_SCORE  (W),
        .SERVE_SWAP (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .point_p1    (point_p1),
        .point_p2    (point_p2),
        .start       (start),
        .score_p1    (score_p1),
        .score_p2    (score_p2),
        .server      (server),
        .adv         (adv),
        .play_active (play_active),
        .game_over   (game_over),
        .winner      (winner)
    );

    logic [13:0] exp_q[$];
    string       tag_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;

    // Reference model: in the deuce region the displayed scores sit at W-1 and
    // m_lead records who holds advantage (0 none, 1 player 1, 2 player 2).
    int m_s[2];
    int m_lead;
    int m_cnt;
    bit m_server;
    bit m_active;
    bit m_over;
    bit m_winner;

    function automatic void model_reset();
        m_s[0] = 0; m_s[1] = 0;
        m_lead = 0; m_cnt = 0;
        m_server = 0; m_active = 0; m_over = 0; m_winner = 0;
    endfunction

    function automatic void finish_game(int who);
        m_s[who] = W;
        m_winner = (who == 1);
        m_over   = 1;
        m_active = 0;
        m_lead   = 0;
    endfunction

    function automatic void model_point(int who);
        if (m_s[0] >= W - 1 && m_s[1] >= W - 1) begin
            if (m_lead == who + 1) begin
                finish_game(who);
            end else begin
                m_lead   = (m_lead == 0) ? who + 1 : 0;
                m_server = !m_server;
            end
        end else if (m_s[who] + 1 == W) begin
            finish_game(who);
        end else begin
            m_s[who] = m_s[who] + 1;
            if (m_s[0] == W - 1 && m_s[1] == W - 1) begin
                m_server = !m_server;
                m_cnt    = 0;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == SW) begin
                    m_server = !m_server;
                    m_cnt    = 0;
                end
            end
        end
    endfunction

    function automatic void model_step(bit p1, bit p2, bit st);
        if (!m_active) begin
            if (st) begin
                if (m_over) begin
                    m_s[0] = 0; m_s[1] = 0;
                    m_lead = 0; m_cnt = 0;
                    m_server = !m_winner;
                    m_over = 0;
                end
                m_active = 1;
            end
        end else if (p1 != p2) begin
            model_point(p2 ? 1 : 0);
        end
    endfunction

    function automatic logic [13:0] model_vec();
        return {4'(m_s[0]), 4'(m_s[1]), m_server, 2'(m_lead), m_active, m_over, m_winner};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {score_p1, score_p2, server, adv, play_active, game_over, winner};
    endfunction

    // winner is only meaningful while game_over is high, except right after reset.
    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp,
                         input bit full);
        logic [13:0] mask;
        mask = (full || exp[1]) ? 14'h3fff : 14'h3ffe;
        n_vec++;
        if ((got & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s @%0t: got s1=%0d s2=%0d srv=%0b adv=%b act=%0b over=%0b win=%0b, expected s1=%0d s2=%0d srv=%0b adv=%b act=%0b over=%0b win=%0b",
                     name, $time, got[13:10], got[9:6], got[5], got[4:3], got[2], got[1], got[0],
                     exp[13:10], exp[9:6], exp[5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(input string name, input bit p1, input bit p2, input bit st);
        @(negedge clk);
        point_p1 = p1;
        point_p2 = p2;
        start    = st;
        model_step(p1, p2, st);
        exp_q.push_back(model_vec());
        tag_q.push_back(name);
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        point_p1 = 0; point_p2 = 0; start = 0;
        #2 rst = 1'b1;
        #1 check("async_rst", dut_vec(), 14'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check(tag_q.pop_front(), dut_vec(), exp_q.pop_front(), 1'b0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of stimulus, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset", dut_vec(), 14'd0, 1'b1);
        rst = 1'b0;

        repeat (3) apply("idle_point", 1, 0, 0);
        apply("idle_conflict", 1, 1, 0);
        apply("start", 0, 0, 1);

        for (int i = 0; i < 7; i++) begin
            apply("straight", 1, 0, 0);
            if (i == 2) apply("start_in_play", 0, 0, 1);
        end
        apply("after_over_p1", 1, 0, 0);
        apply("after_over_p2", 0, 1, 0);
        apply("new_game", 0, 0, 1);

        for (int i = 0; i < 6; i++) begin
            apply("to_deuce_p1", 1, 0, 0);
            apply("to_deuce_p2", 0, 1, 0);
        end
        apply("deuce_p2_adv", 0, 1, 0);
        apply("adv_back", 1, 0, 0);
        apply("deuce_p1_adv", 1, 0, 0);
        apply("adv_win", 1, 0, 0);
        apply("start_and_point", 0, 1, 1);

        apply("pre_conf", 1, 0, 0);
        apply("pre_conf", 0, 1, 0);
        apply("pre_conf", 1, 0, 0);
        apply("pre_conf", 0, 1, 0);
        apply("pre_conf", 1, 0, 0);
        apply("conflict", 1, 1, 0);
        apply("conflict", 1, 1, 0);
        for (int i = 0; i < 4; i++) apply("post_conf", 0, 1, 0);

        async_reset_check();
        apply("start", 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            apply("adv_path_p2", 0, 1, 0);
            apply("adv_path_p1", 1, 0, 0);
        end
        apply("adv_p1", 1, 0, 0);
        async_reset_check();
        apply("idle_after_rst", 1, 0, 0);
        apply("start", 1, 0, 1);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                async_reset_check();
            end else begin
                r = $urandom_range(0, 99);
                if (r < 44)      apply("rand_p1", 1, 0, 0);
                else if (r < 88) apply("rand_p2", 0, 1, 0);
                else if (r < 92) apply("rand_conf", 1, 1, 0);
                else if (r < 96) apply("rand_none", 0, 0, 0);
                else             apply("rand_start", 1'($urandom_range(0, 1)),
                                       1'($urandom_range(0, 1)), 1);
            end
        end

        apply("final", 0, 0, 0);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
